regfile_dump: RTL
=================

Name: regfile_dump

Overview:
- Parametrised, clocked general-purpose register file for the pipeline's decode stage.
- Two combinational read ports and one synchronous write port.
- Optional hardwired-zero register 0.
- A debug dump engine streams every register out over a valid/ready handshake without stalling normal reads and writes.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers.
- ZERO_REG, 1, when 1 register 0 reads as 0 and ignores writes; when 0 it is an ordinary register.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rd_addr_a  input  ADDR_W  read port A address.
- rd_addr_b  input  ADDR_W  read port B address.
- rd_data_a  output  DATA_W  read port A data, combinational.
- rd_data_b  output  DATA_W  read port B data, combinational.
- wr_en  input  1  write enable.
- wr_addr  input  ADDR_W  write address.
- wr_data  input  DATA_W  write data.
- dump_start  input  1  single-cycle request to start a full register dump.
- dump_busy  output  1  dump in progress.
- dump_valid  output  1  dump_idx/dump_data hold a valid beat.
- dump_ready  input  1  consumer accepts the current beat.
- dump_idx  output  ADDR_W  index of the register being presented.
- dump_data  output  DATA_W  captured contents of register dump_idx.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset, asserted asynchronously:
  - all DEPTH registers clear to 0;
  - dump FSM returns to IDLE;
  - dump_busy=0, dump_valid=0, dump_idx=0, dump_data=0;
  - rd_data_a/b therefore read 0.
- Reset mid-dump aborts the dump immediately; no further beats are issued.
- Write:
  - on rising clk with wr_en=1, reg[wr_addr] <= wr_data;
  - suppressed when ZERO_REG=1 and wr_addr=0;
  - write-to-read latency is 1 cycle; a read of the same address in the write cycle returns the old value (see optional feature).
- Read:
  - rd_data_x = reg[rd_addr_x], purely combinational;
  - forced to 0 when ZERO_REG=1 and rd_addr_x=0.
- Both read ports may address the same register in the same cycle; both return identical data.
- Dump FSM states: IDLE, SEND.
  - IDLE: dump_start=1 -> SEND. Load dump_idx=0 and dump_data=reg[0] (0 if ZERO_REG), set dump_valid=1 and dump_busy=1.
  - SEND, dump_valid=1 and dump_ready=0: dump_idx and dump_data hold stable, even if reg[dump_idx] is written meanwhile. dump_data is a snapshot.
  - SEND, handshake (dump_valid & dump_ready) with dump_idx < DEPTH-1: dump_idx <= dump_idx+1 and dump_data <= pre-edge contents of reg[dump_idx+1]. A write to that register on the same edge is not reflected. dump_valid stays 1, so back-to-back beats give 1 beat/cycle.
  - SEND, handshake with dump_idx = DEPTH-1: -> IDLE, dump_valid=0, dump_busy=0, dump_idx=0. dump_data holds its last value.
- dump_start is ignored while dump_busy=1.
- dump_start in the same cycle as the final handshake is ignored; the FSM goes to IDLE.
- dump_busy = (state == SEND).
- Normal reads and writes are fully independent of the dump. No stalls, no priority.
- Exactly DEPTH beats per dump, indices 0..DEPTH-1 in ascending order, no wrap-around.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined: write-through forwarding. When wr_en=1, wr_addr=rd_addr_x, and the address is not the zero register (ZERO_REG=1, addr 0), rd_data_x = wr_data combinationally in the same cycle. Applies independently to ports A and B. The zero register still reads 0. The dump path is unaffected and still captures pre-edge values.
- Not defined: no forwarding; a read of the address being written returns the old value until the next cycle.

Test Plan:
- Reset, ZERO_REG=1:
  - write reg 5 = 32'hDEADBEEF, next cycle rd_addr_a=5 -> rd_data_a=32'hDEADBEEF;
  - write reg 0 = 32'hFFFFFFFF -> rd_data_b at addr 0 = 0.
- Same-cycle read of the address being written: reg 7=32'h1, then wr_en, wr_addr=7, wr_data=32'h2, rd_addr_a=7.
  - RF_BYPASS_EN undefined -> 32'h1 in that cycle, 32'h2 next cycle.
  - RF_BYPASS_EN defined -> 32'h2 in that cycle.
- Preload reg i = i*3, pulse dump_start, hold dump_ready=1:
  - 32 beats on consecutive cycles, dump_idx 0..31, dump_data 0,3,...,93 (beat 0 = 0);
  - then dump_busy=0, dump_valid=0.
- Backpressure:
  - dump_ready=0 for 4 cycles at dump_idx=3 while writing reg 3 = 32'hAAAA -> dump_data stays 9, stable for all 4 cycles;
  - after release, the next beat is idx 4 = 12.
- Assert rst_n=0 asynchronously (mid-cycle) at dump_idx=10:
  - dump_valid and dump_busy drop immediately;
  - all reads return 0;
  - after rst_n=1, a dump_start produces beats from index 0, all 0.
- Pulse dump_start again while dump_busy=1 -> ignored; the dump completes with exactly 32 beats.

Source files
------------

// File: rtl/regfile_dump_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_dump_if
//  Description : Bundle of the register-file read/write ports and the
//                debug-dump valid/ready stream.
//                master : pipeline/consumer side (drives addresses, write data,
//                         dump_start, dump_ready)
//                slave  : register file side (drives read data and dump beats)
//  Revision    : 1.0 - initial release
// ============================================================================
interface regfile_dump_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              dump_start;
  logic              dump_busy;
  logic              dump_valid;
  logic              dump_ready;
  logic [ADDR_W-1:0] dump_idx;
  logic [DATA_W-1:0] dump_data;

  modport master (
    output rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, dump_start, dump_ready,
    input  rd_data_a, rd_data_b, dump_busy, dump_valid, dump_idx, dump_data
  );

  modport slave (
    input  rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, dump_start, dump_ready,
    output rd_data_a, rd_data_b, dump_busy, dump_valid, dump_idx, dump_data
  );
endinterface
`default_nettype wire

// File: rtl/regfile_dump.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_dump
//  Description : Decode-stage register file, 2 combinational read ports and
//                1 synchronous write port, optional hardwired-zero reg 0,
//                plus a debug dump engine streaming all registers out over a
//                valid/ready handshake without stalling reads or writes.
//  Ports       : clk   - system clock, rising edge
//                rst_n - asynchronous active-low reset
//                bus   - regfile_dump_if.slave (read A/B, write, dump stream)
//  Options     : RF_BYPASS_EN - when defined, a read of the address being
//                written returns wr_data in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_dump #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  regfile_dump_if.slave bus
);

  localparam int                DEPTH      = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] c_last_idx = ADDR_W'(DEPTH - 1);
  localparam bit                c_zero_en  = (ZERO_REG != 0);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [ADDR_W-1:0] r_dump_idx;
  logic [DATA_W-1:0] r_dump_data;
  logic              r_dump_valid;

  logic              w_wr_ok;
  logic              w_zero_a;
  logic              w_zero_b;
  logic              w_fwd_a;
  logic              w_fwd_b;
  logic [ADDR_W-1:0] w_next_idx;

  // --------------------------------------------------------------------------
  // Storage: one flop bank per register; reg 0 drops writes when hardwired.
  // --------------------------------------------------------------------------
  assign w_wr_ok = bus.wr_en && !(c_zero_en && (bus.wr_addr == '0));

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_regs[gi] <= '0;
      end else if (w_wr_ok && (bus.wr_addr == ADDR_W'(gi))) begin
        r_regs[gi] <= bus.wr_data;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read ports
  // --------------------------------------------------------------------------
  assign w_zero_a = c_zero_en && (bus.rd_addr_a == '0);
  assign w_zero_b = c_zero_en && (bus.rd_addr_b == '0);

`ifdef RF_BYPASS_EN
  // Forwarding only matters for a write that will land; the zero register is
  // covered by w_zero_x taking precedence below.
  assign w_fwd_a = bus.wr_en && (bus.wr_addr == bus.rd_addr_a);
  assign w_fwd_b = bus.wr_en && (bus.wr_addr == bus.rd_addr_b);
`else
  assign w_fwd_a = 1'b0;
  assign w_fwd_b = 1'b0;
`endif

  assign bus.rd_data_a = w_zero_a ? '0 : (w_fwd_a ? bus.wr_data : r_regs[bus.rd_addr_a]);
  assign bus.rd_data_b = w_zero_b ? '0 : (w_fwd_b ? bus.wr_data : r_regs[bus.rd_addr_b]);

  // --------------------------------------------------------------------------
  // Dump engine. dump_data is a snapshot taken from the flops before the
  // edge, so a write on the same edge never leaks into the beat. The next
  // index is always >= 1, so the zero-register override only applies to the
  // initial load.
  // --------------------------------------------------------------------------
  assign w_next_idx = r_dump_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_dump_idx   <= '0;
      r_dump_data  <= '0;
      r_dump_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.dump_start) begin
            r_state      <= ST_SEND;
            r_dump_idx   <= '0;
            r_dump_data  <= c_zero_en ? '0 : r_regs[0];
            r_dump_valid <= 1'b1;
          end
        end
        ST_SEND: begin
          // dump_start is deliberately not looked at here.
          if (r_dump_valid && bus.dump_ready) begin
            if (r_dump_idx == c_last_idx) begin
              r_state      <= ST_IDLE;
              r_dump_idx   <= '0;
              r_dump_valid <= 1'b0;
            end else begin
              r_dump_idx  <= w_next_idx;
              r_dump_data <= r_regs[w_next_idx];
            end
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_dump_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dump_busy  = (r_state == ST_SEND);
  assign bus.dump_valid = r_dump_valid;
  assign bus.dump_idx   = r_dump_idx;
  assign bus.dump_data  = r_dump_data;

endmodule
`default_nettype wire
